// File: rtl/jtag_host_driver.sv
// Command-driven JTAG master: turns RESET/IDLE/SHIFT_IR/SHIFT_DR commands into
// TCK/TMS/TDI/TRST slot sequences and returns the captured TDO bits.
module jtag_host_driver #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    output logic        trst,
    input  logic        tdo
);

    typedef enum logic [2:0] {
        ST_READY,
        ST_TRST,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } state_t;

    localparam logic [2:0] OP_RESET = 3'd0;
    localparam logic [2:0] OP_IDLE  = 3'd1;
    localparam logic [2:0] OP_IR    = 3'd2;
    localparam logic [2:0] OP_DR    = 3'd3;

    localparam logic [8:0] HALF_M1 = 9'(CLK_DIV - 1);
    localparam logic [8:0] FULL_M1 = 9'(2 * CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] data_q, data_d;
    logic [31:0] cap_q, cap_d;
    logic [31:0] rsp_q, rsp_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        trst_q, trst_d;
    logic        live_q;
    logic        accept;
    logic        slot_start;
    logic        shift_op_q;

    // Index of the final slot spent in a given state.
    function automatic logic [4:0] last_idx(state_t st, logic [2:0] op, logic [4:0] len);
        case (st)
            ST_TRST:  return 5'd1;
            ST_PRE:   return (op == OP_DR) ? 5'd2 : 5'd3;
            ST_SHIFT: return len;
            default:  return 5'd1;
        endcase
    endfunction

    function automatic logic slot_tms(state_t st, logic [4:0] idx, logic [2:0] op, logic [4:0] len);
        case (st)
            ST_TRST:  return 1'b1;
            ST_PRE: begin
                if (op == OP_IR)
                    return idx < 5'd2;
                else if (op == OP_DR)
                    return idx == 5'd0;
                else
                    return 1'b1;
            end
            ST_SHIFT: return (op != OP_IDLE) && (idx == len);
            ST_POST:  return idx == 5'd0;
            default:  return 1'b1;
        endcase
    endfunction

    assign cmd_ready  = live_q && (state_q == ST_READY || state_q == ST_DONE);
    assign accept     = cmd_valid && cmd_ready;
    assign shift_op_q = (op_q == OP_IR) || (op_q == OP_DR);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        len_d      = len_q;
        data_d     = data_q;
        cap_d      = cap_q;
        rsp_d      = rsp_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        slot_start = 1'b0;

        case (state_q)
            ST_READY, ST_DONE: begin
                state_d = ST_READY;
                if (accept) begin
                    op_d   = cmd_op;
                    len_d  = cmd_len;
                    data_d = cmd_data;
                    cap_d  = '0;
                    idx_d  = '0;
                    case (cmd_op)
                        OP_RESET: begin
                            state_d    = ST_TRST;
                            slot_start = 1'b1;
                        end
                        OP_IDLE: begin
                            state_d    = ST_SHIFT;
                            slot_start = 1'b1;
                        end
                        OP_IR, OP_DR: begin
                            state_d    = ST_PRE;
                            slot_start = 1'b1;
                        end
                        // Invalid ops park in PRE for one cycle without driving any slot.
                        default: state_d = ST_PRE;
                    endcase
                end
            end
            default: begin
                if (state_q == ST_PRE && op_q[2]) begin
                    state_d = ST_DONE;
                    rsp_d   = cap_q;
                end else if (cnt_q == FULL_M1) begin
                    if (idx_q == last_idx(state_q, op_q, len_q)) begin
                        idx_d = '0;
                        case (state_q)
                            ST_TRST:  state_d = ST_PRE;
                            ST_PRE:   state_d = (op_q == OP_RESET) ? ST_POST : ST_SHIFT;
                            ST_SHIFT: state_d = (op_q == OP_IDLE) ? ST_DONE : ST_POST;
                            default:  state_d = ST_DONE;
                        endcase
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                    if (state_d == ST_DONE) begin
                        tck_d = 1'b0;
                        rsp_d = cap_q;
                    end else begin
                        slot_start = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == HALF_M1 && state_q != ST_TRST) begin
                        tck_d = 1'b1;
                        if (state_q == ST_SHIFT && shift_op_q)
                            cap_d[idx_q] = tdo;
                    end
                end
            end
        endcase

        if (slot_start) begin
            cnt_d = '0;
            tck_d = 1'b0;
            tms_d = slot_tms(state_d, idx_d, op_d, len_d);
            tdi_d = (state_d == ST_SHIFT && (op_d == OP_IR || op_d == OP_DR)) ? data_d[idx_d] : 1'b0;
        end

        trst_d = (state_d != ST_TRST);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q <= ST_READY;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            rsp_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            trst_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            rsp_q   <= rsp_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trst_q  <= trst_d;
            live_q  <= 1'b1;
        end
    end

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_data  = rsp_q;
    assign busy      = (state_q != ST_READY) && (state_q != ST_DONE);
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign trst      = trst_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Randomized self-checking bench for jtag_host_driver: a slot-level waveform model
// plus a behavioural TAP (IR + bypass, or TDI->TDO loopback) on the JTAG pins.
module tb_jtag_host_driver;

    localparam int DIV = 2;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        tck, tms, tdi, trst;
    logic        tdo;

    always #5 sys_clk = ~sys_clk;

    jtag_host_driver #(.CLK_DIV(DIV)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .trst      (trst),
        .tdo       (tdo)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;
    int rv_count = 0;
    int rises = 0;
    int rises_tms1 = 0;
    logic chk_idle = 1'b0;
    logic loopback = 1'b1;
    logic [3:0] exp_ir = 4'h1;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // TAP model: 0 TLR, 1 RTI, 2..8 DR column, 9..15 IR column.
    int tap_st = 0;
    logic [3:0] ir_sr = 4'h0;
    logic [3:0] ir = 4'h1;
    logic byp = 1'b0;

    function automatic int tap_next(int s, logic t);
        case (s)
            0:  return t ? 0 : 1;
            1:  return t ? 2 : 1;
            2:  return t ? 9 : 3;
            3:  return t ? 5 : 4;
            4:  return t ? 5 : 4;
            5:  return t ? 8 : 6;
            6:  return t ? 7 : 6;
            7:  return t ? 8 : 4;
            8:  return t ? 2 : 1;
            9:  return t ? 0 : 10;
            10: return t ? 12 : 11;
            11: return t ? 12 : 11;
            12: return t ? 15 : 13;
            13: return t ? 14 : 13;
            14: return t ? 15 : 11;
            default: return t ? 2 : 1;
        endcase
    endfunction

    always @(posedge tck or negedge trst) begin
        if (!trst) begin
            tap_st <= 0;
            ir     <= 4'h1;
        end else begin
            case (tap_st)
                3:  byp   <= 1'b0;
                4:  byp   <= tdi;
                10: ir_sr <= 4'b0001;
                11: ir_sr <= {tdi, ir_sr[3:1]};
                15: ir    <= ir_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    assign tdo = loopback ? tdi : ((tap_st == 11) ? ir_sr[0] : ((tap_st == 4) ? byp : 1'b0));

    always @(posedge tck) begin
        rises++;
        if (tms) rises_tms1++;
    end

    // Per-cycle expectation: {tck,tms,tdi,trst,busy,cmd_ready,rsp_valid}.
    typedef struct {
        logic [6:0]  v;
        logic [6:0]  m;
        logic        chk_rsp;
        logic [31:0] rsp;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Builds the slot list from the command rules, then expands it to sys_clk cycles.
    task automatic push_cmd(input logic [2:0] op, input logic [4:0] len, input logic [31:0] data);
        logic [3:0]  slots[$];
        int          n;
        logic [31:0] mask;
        logic [31:0] rsp;
        logic [35:0] v36;
        exp_t        e;
        n    = int'(len) + 1;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        rsp  = '0;
        case (op)
            3'd0: begin
                repeat (2) slots.push_back(4'b1000);
                repeat (5) slots.push_back(4'b1011);
                slots.push_back(4'b0011);
                exp_ir = 4'h1;
            end
            3'd1: repeat (n) slots.push_back(4'b0011);
            3'd2, 3'd3: begin
                slots.push_back(4'b1011);
                if (op == 3'd2) slots.push_back(4'b1011);
                slots.push_back(4'b0011);
                slots.push_back(4'b0011);
                for (int k = 0; k < n; k++) slots.push_back({k == n - 1, data[k], 2'b11});
                slots.push_back(4'b1011);
                slots.push_back(4'b0011);
                if (loopback) rsp = data & mask;
                else if (op == 3'd3) rsp = (data << 1) & mask;
                else rsp = ((data << 4) | 32'd1) & mask;
                if (op == 3'd2) begin
                    v36 = {data, 4'h1};
                    v36 = v36 >> n;
                    exp_ir = v36[3:0];
                end
            end
            default: ;
        endcase
        if (slots.size() == 0) begin
            e.v = 7'b0001100; e.m = 7'b1011111; e.chk_rsp = 1'b0; e.rsp = '0;
            exp_q.push_back(e);
        end
        foreach (slots[s]) begin
            for (int c = 0; c < 2 * DIV; c++) begin
                e.v = {slots[s][0] && (c >= DIV), slots[s][3], slots[s][2], slots[s][1], 3'b100};
                e.m = '1; e.chk_rsp = 1'b0; e.rsp = '0;
                exp_q.push_back(e);
            end
        end
        e.v = 7'b0001011;
        e.m = (slots.size() == 0) ? 7'b1011111 : 7'b1111111;
        e.chk_rsp = 1'b1;
        e.rsp = rsp;
        exp_q.push_back(e);
    endtask

    always begin
        exp_t e;
        logic [6:0] act;
        @(posedge sys_clk);
        #1;
        act = {tck, tms, tdi, trst, busy, cmd_ready, rsp_valid};
        if (rsp_valid === 1'b1) rv_count++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ((act & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL pins cyc=%0d got=%b want=%b mask=%b (tck,tms,tdi,trst,busy,ready,rvalid)",
                         cyc, act, e.v, e.m);
            end
            if (e.chk_rsp) begin
                rsp_cyc = cyc;
                checks++;
                if (rsp_data !== e.rsp) begin
                    errors++;
                    $display("FAIL rsp_data cyc=%0d got=0x%08h want=0x%08h", cyc, rsp_data, e.rsp);
                end
            end
        end else if (chk_idle) begin
            checks++;
            if ({tck, busy, cmd_ready, rsp_valid} !== 4'b0010) begin
                errors++;
                $display("FAIL idle cyc=%0d got=%b want=0010 (tck,busy,ready,rvalid)",
                         cyc, {tck, busy, cmd_ready, rsp_valid});
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [4:0] len, input logic [31:0] data);
        int t;
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 3000) begin
            @(negedge sys_clk);
            t++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout got=0 want=1");
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        push_cmd(op, len, data);
        @(posedge sys_clk);
    endtask

    task automatic drop();
        @(negedge sys_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 5000) begin
            @(posedge sys_clk);
            #2;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL done_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, r0, rv0;
        logic [2:0] op;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_pins", 32'({tck, tms, tdi, trst, busy, cmd_ready, rsp_valid}), 32'b0100000);
        chk("rst_rsp", rsp_data, 32'h0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("rel_ready", 32'(cmd_ready), 32'd1);
        chk("rel_trst", 32'(trst), 32'd1);
        chk_idle = 1'b1;

        r0 = rises_tms1;
        a1 = rises;
        send(3'd0, 5'd0, 32'h0);
        drop();
        wait_done();
        chk("reset_latency", 32'(rsp_cyc - acc_cyc), 32'd32);
        chk("reset_tms1_rises", 32'(rises_tms1 - r0), 32'd5);
        chk("reset_total_rises", 32'(rises - a1), 32'd6);
        chk("reset_tap_rti", 32'(tap_st), 32'd1);

        loopback = 1'b1;
        send(3'd3, 5'd7, 32'hA5);
        drop();
        wait_done();
        chk("loop_rsp", rsp_data, 32'h0000_00A5);
        chk("loop_latency", 32'(rsp_cyc - acc_cyc), 32'd52);
        chk("loop_tap_rti", 32'(tap_st), 32'd1);

        loopback = 1'b0;
        send(3'd3, 5'd31, 32'hFFFF_FFFF);
        drop();
        wait_done();
        chk("bypass_rsp", rsp_data, 32'hFFFF_FFFE);

        send(3'd1, 5'd0, 32'h0);
        a1 = acc_cyc;
        send(3'd2, 5'd3, 32'h2);
        a2 = acc_cyc;
        drop();
        wait_done();
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd5);
        chk("b2b_ir_rsp", rsp_data, 32'h1);
        chk("b2b_ir_value", 32'(ir), 32'h2);
        chk("b2b_ir_latency", 32'(rsp_cyc - acc_cyc), 32'd40);

        a1 = rises;
        send(3'd5, 5'(($urandom)), $urandom);
        drop();
        wait_done();
        chk("inv_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
        chk("inv_rsp", rsp_data, 32'h0);
        chk("inv_no_tck", 32'(rises - a1), 32'd0);

        for (int g = 0; g < 50; g++) begin
            int nb;
            loopback = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) op = 3'd0;
                else if (r < 3) op = 3'd1;
                else if (r < 6) op = 3'd2;
                else if (r < 9) op = 3'd3;
                else op = 3'($urandom_range(4, 7));
                send(op, 5'($urandom), $urandom);
            end
            drop();
            wait_done();
            chk("rand_ir", 32'(ir), 32'(exp_ir));
            chk("rand_tap_rti", 32'(tap_st), 32'd1);
            repeat ($urandom_range(0, 3)) @(posedge sys_clk);
        end

        loopback = 1'b1;
        send(3'd3, 5'd15, $urandom);
        drop();
        repeat (21) @(negedge sys_clk);
        rv0 = rv_count;
        chk_idle = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        @(posedge sys_clk);
        #1;
        chk("midrst_pins", 32'({tck, tms, tdi, trst, busy, cmd_ready, rsp_valid}), 32'b0100000);
        chk("midrst_rsp", rsp_data, 32'h0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_trst", 32'(trst), 32'd1);
        exp_ir = 4'h1;
        chk_idle = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        chk("midrst_no_rsp", 32'(rv_count - rv0), 32'd0);
        chk("midrst_tap_tlr", 32'(tap_st), 32'd0);

        send(3'd0, 5'd0, 32'h0);
        drop();
        wait_done();
        chk("post_rst_tap_rti", 32'(tap_st), 32'd1);
        send(3'd3, 5'd3, 32'h9);
        drop();
        wait_done();
        chk("post_rst_loop_rsp", rsp_data, 32'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
